// File: rtl/cv_ctrl_ports.sv
// cv_ctrl_ports: ColecoVision controller-port engine for NUM_PORTS players.
// Turns packed joystick words into registered active-low port lines and
// generates spinner quadrature on p7/p9.
// Optional build macro CV_TURBO_EN adds a per-port fire-button turbo toggler.

module cv_ctrl_port_lane #(
   parameter int SPIN_W    = 8,
   parameter int SPIN_DIV  = 1024,
   parameter int PEND_W    = 10,
   parameter int TURBO_DIV = 178000
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ce,
   input  logic [31:0]       joy_i,
   input  logic [SPIN_W-1:0] spin_dx_i,
   input  logic              spin_stb_i,
   input  logic              sel_kp_n_i,
   input  logic              sel_js_n_i,
   input  logic              turbo_i,
   output logic [3:0]        ctrl_o,
   output logic              fire_n_o,
   output logic              spin_a_o,
   output logic              spin_b_o
);
   // Sum is wide enough for pending + dx +/- 1 without overflow before saturation
   localparam int SW = ((PEND_W > SPIN_W) ? PEND_W : SPIN_W) + 2;
   localparam int DW = $clog2(SPIN_DIV);
   localparam logic signed [SW-1:0] S_ONE = SW'(1);
   localparam logic signed [SW-1:0] S_MAX = SW'((1 << (PEND_W-1)) - 1);
   localparam logic signed [SW-1:0] S_MIN = -S_MAX - S_ONE;

   logic [3:0] ctrl_q, ctrl_d, kp_code, kp_c, js_c;
   logic       fire_q, fire_d, f1, f2;
   logic       unused_hi;

   assign unused_hi = ^joy_i[31:20];

`ifdef CV_TURBO_EN
   localparam int TW = $clog2(TURBO_DIV);
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          ton_q, ton_d, tprev_q;

   // Turbo toggler: free-running half-period counter, restarted in the on-half on turbo rise
   always_comb begin
      tcnt_d = tcnt_q + TW'(1);
      ton_d  = ton_q;
      if (turbo_i && !tprev_q) begin
         tcnt_d = '0;
         ton_d  = 1'b1;
      end else if (tcnt_q == TW'(TURBO_DIV-1)) begin
         tcnt_d = '0;
         ton_d  = ~ton_q;
      end
   end

   // Turbo toggler state
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         tcnt_q  <= '0;
         ton_q   <= 1'b0;
         tprev_q <= 1'b0;
      end else if (ce) begin
         tcnt_q  <= tcnt_d;
         ton_q   <= ton_d;
         tprev_q <= turbo_i;
      end
   end

   assign f1 = joy_i[4] & (~turbo_i | ton_q);
   assign f2 = joy_i[5] & (~turbo_i | ton_q);
`else
   localparam int UNUSED_TURBO_DIV = TURBO_DIV;
   logic unused_turbo;
   assign unused_turbo = turbo_i;
   assign f1 = joy_i[4];
   assign f2 = joy_i[5];
`endif

   // Keypad priority encoder: lowest-numbered key wins, then *, #, purple, blue
   always_comb begin
      kp_code = 4'b1111;
      if      (joy_i[8])  kp_code = 4'b0011;
      else if (joy_i[9])  kp_code = 4'b1110;
      else if (joy_i[10]) kp_code = 4'b1101;
      else if (joy_i[11]) kp_code = 4'b0110;
      else if (joy_i[12]) kp_code = 4'b0001;
      else if (joy_i[13]) kp_code = 4'b1001;
      else if (joy_i[14]) kp_code = 4'b0111;
      else if (joy_i[15]) kp_code = 4'b1100;
      else if (joy_i[16]) kp_code = 4'b1000;
      else if (joy_i[17]) kp_code = 4'b1011;
      else if (joy_i[6])  kp_code = 4'b1010;
      else if (joy_i[7])  kp_code = 4'b0101;
      else if (joy_i[18]) kp_code = 4'b0100;
      else if (joy_i[19]) kp_code = 4'b0010;
   end

   // Each selected segment pulls lines low; an unselected one contributes all-ones
   assign kp_c   = sel_kp_n_i ? 4'b1111 : kp_code;
   assign js_c   = sel_js_n_i ? 4'b1111 : ~{joy_i[3], joy_i[0], joy_i[2], joy_i[1]};
   assign ctrl_d = kp_c & js_c;
   assign fire_d = (sel_kp_n_i | ~f2) & (sel_js_n_i | ~f1);

   // Port line registers
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         ctrl_q <= 4'b1111;
         fire_q <= 1'b1;
      end else if (ce) begin
         ctrl_q <= ctrl_d;
         fire_q <= fire_d;
      end
   end

   logic signed [PEND_W-1:0] pend_q, pend_d;
   logic signed [SPIN_W-1:0] sdx;
   logic signed [SW-1:0]     sum;
   logic [DW-1:0]            div_q, div_d;
   logic [1:0]               ph_q, ph_d;
   logic                     step;

   assign sdx = spin_dx_i;

   // Spinner: accumulate strobed deltas, step one phase toward zero every SPIN_DIV ticks
   always_comb begin
      step  = (pend_q != '0) && (div_q == DW'(SPIN_DIV-1));
      div_d = div_q + DW'(1);
      if (pend_q == '0 || step) div_d = '0;
      sum  = SW'(pend_q);
      ph_d = ph_q;
      if (spin_stb_i) sum = sum + SW'(sdx);
      if (step) begin
         if (!pend_q[PEND_W-1]) begin
            sum  = sum - S_ONE;
            ph_d = ph_q + 2'd1;
         end else begin
            sum  = sum + S_ONE;
            ph_d = ph_q - 2'd1;
         end
      end
      if      (sum > S_MAX) pend_d = S_MAX[PEND_W-1:0];
      else if (sum < S_MIN) pend_d = S_MIN[PEND_W-1:0];
      else                  pend_d = sum[PEND_W-1:0];
   end

   // Spinner state
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         pend_q <= '0;
         div_q  <= '0;
         ph_q   <= 2'd0;
      end else if (ce) begin
         pend_q <= pend_d;
         div_q  <= div_d;
         ph_q   <= ph_d;
      end
   end

   // Phase index 0..3 maps to gray {A,B} = 00,01,11,10
   assign spin_a_o = ph_q[1];
   assign spin_b_o = ph_q[1] ^ ph_q[0];
   assign ctrl_o   = ctrl_q;
   assign fire_n_o = fire_q;
endmodule

module cv_ctrl_ports #(
   parameter int NUM_PORTS = 2,
   parameter int SPIN_W    = 8,
   parameter int SPIN_DIV  = 1024,
   parameter int PEND_W    = 10,
   parameter int TURBO_DIV = 178000
) (
   input  logic                        clk_sys,
   input  logic                        reset,
   input  logic                        ce,
   input  logic                        swap_i,
   input  logic [32*NUM_PORTS-1:0]     joy_i,
   input  logic [SPIN_W*NUM_PORTS-1:0] spin_dx_i,
   input  logic [NUM_PORTS-1:0]        spin_stb_i,
   input  logic [NUM_PORTS-1:0]        sel_kp_n_i,
   input  logic [NUM_PORTS-1:0]        sel_js_n_i,
   input  logic [NUM_PORTS-1:0]        turbo_i,
   output logic [4*NUM_PORTS-1:0]      ctrl_o,
   output logic [NUM_PORTS-1:0]        fire_n_o,
   output logic [NUM_PORTS-1:0]        spin_a_o,
   output logic [NUM_PORTS-1:0]        spin_b_o
);
   logic [NUM_PORTS-1:0][31:0]       joy_a, joy_s;
   logic [NUM_PORTS-1:0][SPIN_W-1:0] dx_a, dx_s;
   logic [NUM_PORTS-1:0]             stb_s, trb_s;

   assign joy_a = joy_i;
   assign dx_a  = spin_dx_i;

   generate
      if (NUM_PORTS >= 2) begin : g_swap
         // Player-side inputs of ports 0/1 are exchanged; per-port state stays put
         always_comb begin
            joy_s = joy_a;
            dx_s  = dx_a;
            stb_s = spin_stb_i;
            trb_s = turbo_i;
            if (swap_i) begin
               joy_s[0] = joy_a[1];      joy_s[1] = joy_a[0];
               dx_s[0]  = dx_a[1];       dx_s[1]  = dx_a[0];
               stb_s[0] = spin_stb_i[1]; stb_s[1] = spin_stb_i[0];
               trb_s[0] = turbo_i[1];    trb_s[1] = turbo_i[0];
            end
         end
      end else begin : g_noswap
         logic unused_swap;
         assign unused_swap = swap_i;
         assign joy_s = joy_a;
         assign dx_s  = dx_a;
         assign stb_s = spin_stb_i;
         assign trb_s = turbo_i;
      end

      for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
         cv_ctrl_port_lane #(
            .SPIN_W(SPIN_W), .SPIN_DIV(SPIN_DIV), .PEND_W(PEND_W), .TURBO_DIV(TURBO_DIV)
         ) u_lane (
            .clk_sys   (clk_sys),
            .reset     (reset),
            .ce        (ce),
            .joy_i     (joy_s[g]),
            .spin_dx_i (dx_s[g]),
            .spin_stb_i(stb_s[g]),
            .sel_kp_n_i(sel_kp_n_i[g]),
            .sel_js_n_i(sel_js_n_i[g]),
            .turbo_i   (trb_s[g]),
            .ctrl_o    (ctrl_o[4*g +: 4]),
            .fire_n_o  (fire_n_o[g]),
            .spin_a_o  (spin_a_o[g]),
            .spin_b_o  (spin_b_o[g])
         );
      end
   endgenerate
endmodule
